// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and pairs each returned word
// with its PC. Handles stall, single-cycle branch redirect, flush, sticky alignment/bounds faults and an accepted-fetch counter.
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned MEM_SIZE = 4095,
   parameter int unsigned COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               branch_taken,
   input  logic [63:0]        branch_target,
   output logic [63:0]        imem_addr,
   input  logic [31:0]        imem_instr,
   output logic [63:0]        if_pc,
   output logic [31:0]        if_instr,
   output logic               if_valid,
   output logic               fetch_fault,
   output logic [63:0]        fault_pc,
   output logic [COUNT_W-1:0] fetch_count
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Highest byte address at which a whole 4-byte word still fits in memory
   localparam logic [63:0] PC_LIMIT = 64'(MEM_SIZE) - 64'd4;

   state_t             state_q, state_d;
   logic [63:0]        fetch_pc_q, fetch_pc_d;
   logic [63:0]        fault_pc_q, fault_pc_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [63:0]        addr_s;
   logic [31:0]        instr_s;
   logic               valid_s;
   logic               bad_s;

   // Next-state, fetch address and presented-slot decode
   always_comb begin
      state_d    = state_q;
      fault_pc_d = fault_pc_q;
      count_d    = count_q;
      addr_s     = RESET_PC;
      instr_s    = 32'h0;
      valid_s    = 1'b0;
      bad_s      = 1'b0;
      case (state_q)
         BOOT: begin
            addr_s  = RESET_PC;
            state_d = RUN;
         end
         RUN: begin
            bad_s   = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q > PC_LIMIT);
            valid_s = !bad_s && !flush;
            instr_s = imem_instr;
            // A stalled slot is held by re-reading the same word from memory
            if (bad_s) begin
               addr_s = fetch_pc_q;
            end else if (branch_taken) begin
               addr_s = branch_target;
            end else if (stall) begin
               addr_s = fetch_pc_q;
            end else begin
               addr_s = fetch_pc_q + 64'd4;
            end
            if (bad_s) begin
               state_d    = FAULT;
               fault_pc_d = fetch_pc_q;
            end else begin
               state_d    = RUN;
            end
            if (valid_s && !stall) begin
               count_d = count_q + COUNT_W'(1'b1);
            end else begin
               count_d = count_q;
            end
         end
         FAULT: begin
            addr_s  = fault_pc_q;
            state_d = FAULT;
         end
         default: begin
            addr_s  = RESET_PC;
            state_d = BOOT;
         end
      endcase
      fetch_pc_d = addr_s;
   end

   // State, PC, fault address and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         fault_pc_q <= 64'h0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fault_pc_q <= fault_pc_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr   = addr_s;
   assign if_pc       = fetch_pc_q;
   assign if_instr    = instr_s;
   assign if_valid    = valid_s;
   assign fetch_fault = (state_q == FAULT);
   assign fault_pc    = fault_pc_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (large and 64-byte memory) share stimulus; a
// behavioural model checks every cycle at the falling edge and directed literals pin the model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall, flush, branch_taken;
   logic [63:0] branch_target;

   logic [63:0] addr_b, pc_b, fpc_b, addr_s, pc_s, fpc_s;
   logic [31:0] instr_b, instr_s, cnt_b, cnt_s, mem_b, mem_s;
   logic        valid_b, fault_b, valid_s, fault_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(64'h0), .MEM_SIZE(4095), .COUNT_W(32)) dut_big (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(addr_b), .imem_instr(mem_b), .if_pc(pc_b), .if_instr(instr_b),
      .if_valid(valid_b), .fetch_fault(fault_b), .fault_pc(fpc_b), .fetch_count(cnt_b));

   instruction_fetch #(.RESET_PC(64'h0), .MEM_SIZE(64), .COUNT_W(32)) dut_small (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(addr_s), .imem_instr(mem_s), .if_pc(pc_s), .if_instr(instr_s),
      .if_valid(valid_s), .fetch_fault(fault_s), .fault_pc(fpc_s), .fetch_count(cnt_s));

   function automatic logic [31:0] instr_at(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Instruction memory: one-cycle registered read, reset to zero
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_b <= 32'h0;
         mem_s <= 32'h0;
      end else begin
         mem_b <= instr_at(addr_b);
         mem_s <= instr_at(addr_s);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model per instance: PC of the slot being presented, fault record, accepted count
   logic [63:0] o_addr[2], o_pc[2], o_fpc[2];
   logic [31:0] o_instr[2], o_cnt[2];
   logic        o_valid[2], o_fault[2];
   assign o_addr[0] = addr_b;  assign o_addr[1] = addr_s;
   assign o_pc[0]   = pc_b;    assign o_pc[1]   = pc_s;
   assign o_fpc[0]  = fpc_b;   assign o_fpc[1]  = fpc_s;
   assign o_instr[0]= instr_b; assign o_instr[1]= instr_s;
   assign o_cnt[0]  = cnt_b;   assign o_cnt[1]  = cnt_s;
   assign o_valid[0]= valid_b; assign o_valid[1]= valid_s;
   assign o_fault[0]= fault_b; assign o_fault[1]= fault_s;

   logic [63:0] lim[2]     = '{64'd4091, 64'd60};
   logic        m_booted[2] = '{1'b0, 1'b0};
   logic        m_faulted[2] = '{1'b0, 1'b0};
   logic [63:0] m_pc[2]    = '{64'h0, 64'h0};
   logic [63:0] m_fpc[2]   = '{64'h0, 64'h0};
   logic [31:0] m_cnt[2]   = '{32'h0, 32'h0};

   // Compare both instances to the model each falling edge, then advance the model
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         string       t;
         logic        isbad, ev;
         logic [63:0] ea;
         t = (i == 0) ? "big" : "small";
         if (!reset_n) begin
            chk({t, ".rst_valid"}, o_valid[i], 0);
            chk({t, ".rst_fault"}, o_fault[i], 0);
            chk({t, ".rst_pc"}, o_pc[i], 64'h0);
            chk({t, ".rst_instr"}, o_instr[i], 0);
            chk({t, ".rst_addr"}, o_addr[i], 64'h0);
            chk({t, ".rst_cnt"}, o_cnt[i], 0);
            chk({t, ".rst_fpc"}, o_fpc[i], 0);
            m_booted[i] = 1'b0; m_faulted[i] = 1'b0;
            m_pc[i] = 64'h0; m_fpc[i] = 64'h0; m_cnt[i] = 32'h0;
         end else if (!m_booted[i]) begin
            chk({t, ".boot_valid"}, o_valid[i], 0);
            chk({t, ".boot_addr"}, o_addr[i], 64'h0);
            chk({t, ".boot_fault"}, o_fault[i], 0);
            chk({t, ".boot_cnt"}, o_cnt[i], m_cnt[i]);
            m_booted[i] = 1'b1;
            m_pc[i] = 64'h0;
         end else if (m_faulted[i]) begin
            chk({t, ".flt_valid"}, o_valid[i], 0);
            chk({t, ".flt_fault"}, o_fault[i], 1);
            chk({t, ".flt_addr"}, o_addr[i], m_fpc[i]);
            chk({t, ".flt_fpc"}, o_fpc[i], m_fpc[i]);
            chk({t, ".flt_cnt"}, o_cnt[i], m_cnt[i]);
         end else begin
            isbad = (m_pc[i] % 64'd4 != 64'd0) || (m_pc[i] + 64'd4 > lim[i] + 64'd4);
            ev = !isbad && !flush;
            if (isbad)             ea = m_pc[i];
            else if (branch_taken) ea = branch_target;
            else if (stall)        ea = m_pc[i];
            else                   ea = m_pc[i] + 64'd4;
            chk({t, ".valid"}, o_valid[i], ev);
            chk({t, ".fault"}, o_fault[i], 0);
            chk({t, ".pc"}, o_pc[i], m_pc[i]);
            chk({t, ".instr"}, o_instr[i], instr_at(m_pc[i]));
            chk({t, ".addr"}, o_addr[i], ea);
            chk({t, ".cnt"}, o_cnt[i], m_cnt[i]);
            chk({t, ".fpc"}, o_fpc[i], m_fpc[i]);
            if (ev && !stall) m_cnt[i] = m_cnt[i] + 32'd1;
            if (isbad) begin
               m_faulted[i] = 1'b1;
               m_fpc[i] = m_pc[i];
            end
            m_pc[i] = ea;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
      step(); step(); #1;
      chk("L.rst_valid", valid_b, 0); chk("L.rst_addr", addr_b, 64'h0); chk("L.rst_cnt", cnt_b, 0);
      step(); reset_n = 1'b1; #1;
      chk("L.boot_valid", valid_b, 0);
      step(); #1; chk("L.c1_pc", pc_b, 64'h0); chk("L.c1_instr", instr_b, 32'hC0DE0000); chk("L.c1_valid", valid_b, 1);
      step(); #1; chk("L.c2_pc", pc_b, 64'h4); chk("L.c2_instr", instr_b, 32'hC0DE0004);
      step(); #1; chk("L.c3_pc", pc_b, 64'h8); chk("L.c3_cnt", cnt_b, 2);
      stall = 1'b1; #1; chk("L.stall_addr", addr_b, 64'h8);
      step(); #1; chk("L.st1_pc", pc_b, 64'h8); chk("L.st1_instr", instr_b, 32'hC0DE0008); chk("L.st1_cnt", cnt_b, 2);
      step(); stall = 1'b0; #1; chk("L.st2_pc", pc_b, 64'h8); chk("L.st2_cnt", cnt_b, 2);
      step(); #1; chk("L.c4_pc", pc_b, 64'hC); chk("L.c4_cnt", cnt_b, 3);
      step(); #1; chk("L.c5_pc", pc_b, 64'h10);
      branch_taken = 1'b1; branch_target = 64'h40; flush = 1'b1; #1;
      chk("L.flush_valid", valid_b, 0);
      step(); branch_taken = 1'b0; flush = 1'b0; #1;
      chk("L.br_pc", pc_b, 64'h40); chk("L.br_valid", valid_b, 1);
      step(); branch_taken = 1'b1; branch_target = 64'h40; flush = 1'b1; stall = 1'b1; #1;
      chk("L.brst_valid", valid_b, 0); chk("L.brst_addr", addr_b, 64'h40);
      step(); branch_taken = 1'b0; flush = 1'b0; stall = 1'b0; #1;
      chk("L.brst_pc", pc_b, 64'h40); chk("L.brst_nvalid", valid_b, 1);
      step(); branch_taken = 1'b1; branch_target = 64'h42;
      step(); branch_taken = 1'b0; #1;
      chk("L.mis_pc", pc_b, 64'h42); chk("L.mis_valid", valid_b, 0); chk("L.mis_fault", fault_b, 0);
      step(); #1; chk("L.flt", fault_b, 1); chk("L.flt_pc", fpc_b, 64'h42);
      branch_taken = 1'b1; branch_target = 64'h0;
      step(); branch_taken = 1'b0; #1;
      chk("L.flt_sticky", fault_b, 1); chk("L.flt_pc2", fpc_b, 64'h42); chk("L.flt_valid", valid_b, 0);
      step(); #2; reset_n = 1'b0; #1;
      chk("L.mrst_valid", valid_b, 0); chk("L.mrst_cnt", cnt_b, 0); chk("L.mrst_addr", addr_b, 64'h0);
      chk("L.mrst_fault", fault_b, 0);
      step(); step(); reset_n = 1'b1; #1;
      chk("L.boot2_valid", valid_b, 0);
      step(); #1; chk("L.r1_pc", pc_b, 64'h0); chk("L.r1_instr", instr_b, 32'hC0DE0000);
      step(); #1; chk("L.r2_pc", pc_b, 64'h4);
      step(); #1; chk("L.r3_pc", pc_b, 64'h8); chk("L.r3_cnt", cnt_b, 2);
      branch_taken = 1'b1; branch_target = 64'h30;
      step(); branch_taken = 1'b0; #1;
      chk("S.pc30", pc_s, 64'h30); chk("S.v30", valid_s, 1);
      step(); step();
      step(); #1; chk("S.pc3c", pc_s, 64'h3C); chk("S.v3c", valid_s, 1);
      step(); #1; chk("S.pc40", pc_s, 64'h40); chk("S.v40", valid_s, 0); chk("L.v40", valid_b, 1);
      step(); #1; chk("S.flt", fault_s, 1); chk("S.flt_pc", fpc_s, 64'h40);
      chk("L.pc44", pc_b, 64'h44); chk("L.v44", valid_b, 1);
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
